vec_issue_ctrl: RTL
===================

VEC_ISSUE_CTRL -- requirements
Module: vec_issue_ctrl

Interface
REQ-001 Parameter: XLEN, 32, scalar/instruction width.
REQ-002 Parameter: IDX_W, 3, micro-op index width; 8 micro-ops max for LMUL=8.
REQ-003 clk  input  1  single clock; all state is rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 inst_valid  input  1  scalar core offers an instruction.
REQ-006 inst_ready  output  1  controller can accept an instruction.
REQ-007 is_vec  input  1  decoder flag: the offered instruction is a vector instruction.
REQ-008 vec_inst  input  XLEN  raw instruction word.
REQ-009 csr_vlmul  input  3  current vtype.vlmul.
REQ-010 csr_vl_zero  input  1  current vl equals 0.
REQ-011 flush  input  1  synchronous abort request.
REQ-012 vl_sel, vtype_sel, lumop_sel  output  1 each  operand-mux selects to the decoder.
REQ-013 csr_wr_en  output  1  commits vl/vtype for a configuration instruction.
REQ-014 uop_valid / uop_ready  output / input  1 / 1  micro-op handshake with the vector lanes.
REQ-015 uop_vd, uop_vs1, uop_vs2  output  5 each  register numbers for the current micro-op.
REQ-016 uop_idx  output  IDX_W  index of the current micro-op within the register group.
REQ-017 uop_last  output  1  current micro-op is the final one of the group.
REQ-018 exec_done  input  1  lanes finished the last micro-op.
REQ-019 done  output  1  one-cycle pulse when an instruction retires.
REQ-020 illegal  output  1  one-cycle pulse when an instruction is rejected.
REQ-021 busy  output  1  stall to the scalar core; high whenever state is not IDLE.

Function
REQ-022 FSM states: IDLE, CONFIG, ISSUE, WAIT_DONE.
REQ-023 inst_ready is 1 only in IDLE; an instruction is accepted when inst_valid, inst_ready and is_vec are all 1.
REQ-024 On accept, vec_inst is registered; all micro-op outputs derive from the registered copy.
REQ-025 Configuration instruction is opcode 0x57 with funct3=3'b111; on accept, go to CONFIG.
REQ-026 CONFIG lasts exactly 1 cycle: csr_wr_en=1; vl_sel = (inst[31:30]==2'b11); vtype_sel = (inst[31]==0) or (inst[31:30]==2'b11); next state IDLE; done pulses in the same cycle.
REQ-027 Group size G: vlmul 0..3 gives 1,2,4,8; vlmul 5..7 (fractional) gives 1; vlmul 4 is illegal.
REQ-028 Alignment check: vd and vs2 must be multiples of G; vs1 must also be a multiple of G when funct3 is OPIVV (000) or OPMVV (010).
REQ-029 Rejection: vlmul=4 or any alignment failure (opcode 0x57 only) → illegal pulses 1 cycle after accept; stay in IDLE; no micro-op is issued.
REQ-030 Zero vl: if csr_vl_zero=1 at accept for a non-configuration instruction → done pulses 1 cycle after accept; no micro-op is issued.
REQ-031 Otherwise go to ISSUE with idx=0; uop_valid first rises the cycle after accept.
REQ-032 In ISSUE: uop_vd = vd+idx, uop_vs1 = vs1+idx, uop_vs2 = vs2+idx, all 5-bit.
REQ-033 uop_last = (idx == G-1).
REQ-034 Micro-op outputs are held stable while uop_valid=1 and uop_ready=0.
REQ-035 On uop_valid and uop_ready: idx increments; if uop_last, go to WAIT_DONE.
REQ-036 lumop_sel = 1 in ISSUE for opcode 0x07/0x27 with mop=2'b00; otherwise 0.
REQ-037 In WAIT_DONE: on exec_done → done pulses the next cycle, state returns to IDLE; exec_done in any other state is ignored.
REQ-038 flush has priority over every transition: next state IDLE, idx=0, no done or illegal pulse; flush coincident with an accept drops that instruction.
REQ-039 csr_wr_en, uop_valid, done and illegal are never 1 in the same cycle, except csr_wr_en with done in CONFIG.

Reset
REQ-040 rst_n=0 asynchronously forces state IDLE and idx=0, and drives every output to 0 except inst_ready=1, including reset mid-ISSUE or mid-WAIT_DONE.
REQ-041 After rst_n rises, the first accept is possible on the first clock edge.

Verification
REQ-042 vsetvli (0x00057557-type, inst[31]=0) → CONFIG 1 cycle: csr_wr_en=1, vl_sel=0, vtype_sel=1, done=1, busy=1 for that cycle.
REQ-043 vadd.vv vd=8, vs2=16, vs1=24 with vlmul=2, uop_ready held 1 → 4 micro-ops on consecutive cycles: vd 8..11, vs2 16..19, vs1 24..27; uop_last only on idx=3; exec_done → done next cycle.
REQ-044 Same instruction with vd=9 → illegal pulse 1 cycle after accept, uop_valid stays 0, inst_ready stays 1.
REQ-045 vle32 with vlmul=1, uop_ready low for 3 cycles on idx=0 → outputs held, lumop_sel=1; 2 micro-ops total after release.
REQ-046 csr_vl_zero=1 with vmul.vv → done 1 cycle after accept, no uop_valid.
REQ-047 Drop rst_n in ISSUE at idx=2 → all outputs 0 (inst_ready=1) immediately; flush in WAIT_DONE → IDLE next cycle, no done pulse.

Source files
------------

// File: rtl/vec_issue_ctrl.sv
// Vector issue controller: accepts vector instructions from the scalar core, commits
// configuration instructions, and cracks register-group ops into per-register micro-ops.
module vec_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic             is_vec,
    input  logic [XLEN-1:0]  vec_inst,
    input  logic [2:0]       csr_vlmul,
    input  logic             csr_vl_zero,
    input  logic             flush,
    output logic             vl_sel,
    output logic             vtype_sel,
    output logic             lumop_sel,
    output logic             csr_wr_en,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [4:0]       uop_vd,
    output logic [4:0]       uop_vs1,
    output logic [4:0]       uop_vs2,
    output logic [IDX_W-1:0] uop_idx,
    output logic             uop_last,
    input  logic             exec_done,
    output logic             done,
    output logic             illegal,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CONFIG, ISSUE, WAIT_DONE} state_t;

    state_t           state, nxt;
    logic [IDX_W-1:0] idx, gm1_q;
    logic [6:0]       op_q;
    logic [4:0]       vd_q, vs1_q, vs2_q;
    logic [1:0]       mop_q, hi_q;
    logic             done_q, illegal_q;

    // Decode of the offered word, used only to steer the accept decision.
    logic [6:0]       in_op;
    logic [2:0]       in_f3;
    logic [4:0]       in_vd, in_vs1, in_vs2, gmask;
    logic [IDX_W-1:0] in_gm1;
    logic             in_cfg, in_bad, accept, fire;
    logic             unused_bits;

    assign unused_bits = ^vec_inst;
    assign in_op  = vec_inst[6:0];
    assign in_vd  = vec_inst[11:7];
    assign in_f3  = vec_inst[14:12];
    assign in_vs1 = vec_inst[19:15];
    assign in_vs2 = vec_inst[24:20];
    assign in_cfg = (in_op == 7'h57) && (in_f3 == 3'b111);

    // Fractional and unit LMUL both occupy a single register.
    always_comb begin
        case (csr_vlmul)
            3'd1:    in_gm1 = IDX_W'(1);
            3'd2:    in_gm1 = IDX_W'(3);
            3'd3:    in_gm1 = IDX_W'(7);
            default: in_gm1 = '0;
        endcase
    end

    assign gmask  = 5'(in_gm1);
    assign in_bad = (csr_vlmul == 3'd4) ||
                    ((in_op == 7'h57) &&
                     (((in_vd & gmask) != 5'd0) || ((in_vs2 & gmask) != 5'd0) ||
                      (((in_f3 == 3'b000) || (in_f3 == 3'b010)) && ((in_vs1 & gmask) != 5'd0))));

    assign inst_ready = (state == IDLE);
    assign accept     = inst_valid && inst_ready && is_vec && !flush;
    assign fire       = uop_valid && uop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (accept) nxt = in_cfg ? CONFIG : ((in_bad || csr_vl_zero) ? IDLE : ISSUE);
            CONFIG:    nxt = IDLE;
            ISSUE:     if (fire && uop_last) nxt = WAIT_DONE;
            WAIT_DONE: if (exec_done) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
        if (flush) nxt = IDLE;
    end

    always_comb begin
        busy      = (state != IDLE);
        csr_wr_en = (state == CONFIG) && !flush;
        vl_sel    = (state == CONFIG) && (hi_q == 2'b11);
        vtype_sel = (state == CONFIG) && (!hi_q[1] || (hi_q == 2'b11));
        uop_valid = (state == ISSUE);
        uop_vd    = '0;
        uop_vs1   = '0;
        uop_vs2   = '0;
        uop_idx   = '0;
        uop_last  = 1'b0;
        lumop_sel = 1'b0;
        if (state == ISSUE) begin
            uop_vd    = vd_q  + 5'(idx);
            uop_vs1   = vs1_q + 5'(idx);
            uop_vs2   = vs2_q + 5'(idx);
            uop_idx   = idx;
            uop_last  = (idx == gm1_q);
            lumop_sel = ((op_q == 7'h07) || (op_q == 7'h27)) && (mop_q == 2'b00);
        end
        done    = (done_q || (state == CONFIG)) && !flush;
        illegal = illegal_q && !flush;
    end

    // Instruction fields, group size, micro-op index and the delayed retire/reject pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            gm1_q     <= '0;
            op_q      <= '0;
            vd_q      <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            mop_q     <= '0;
            hi_q      <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= !flush && ((accept && !in_cfg && !in_bad && csr_vl_zero) ||
                                    ((state == WAIT_DONE) && exec_done));
            illegal_q <= accept && !in_cfg && in_bad;
            if (accept) begin
                op_q  <= in_op;
                vd_q  <= in_vd;
                vs1_q <= in_vs1;
                vs2_q <= in_vs2;
                mop_q <= vec_inst[27:26];
                hi_q  <= vec_inst[31:30];
                gm1_q <= in_gm1;
            end
            if (flush || state != ISSUE) idx <= '0;
            else if (fire)               idx <= idx + 1'b1;
        end
    end
endmodule
